// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared register width, MDU sequencer states and NOP encoding
package hazard_ctrl_pkg;
    localparam int REG_BITS = 5;
    typedef enum logic {RUN, BUSY} hazard_state_e;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/hazard_ctrl_mdu_seq.sv
// hazard_ctrl_mdu_seq: fixed-latency MUL/DIV freeze sequencer (RUN/BUSY + countdown)
module hazard_ctrl_mdu_seq
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 4
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic mdu_op_i,
    input  logic mem_frz_i,
    output logic mdu_frz_o,
    output logic mdu_start_o,
    output logic mdu_busy_o
);
    hazard_state_e state;
    logic [CNT_W-1:0] cnt;
    logic done;

    assign done        = state == BUSY && cnt == '0 && !mem_frz_i;
    assign mdu_start_o = state == RUN && mdu_op_i && !mem_frz_i;
    assign mdu_busy_o  = state == BUSY;
    assign mdu_frz_o   = (state == RUN && mdu_op_i) || (state == BUSY && !done);

    // start countdown on an unstalled MDU op; release once it hits zero with memory ready
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= RUN;
            cnt   <= '0;
        end else if (mdu_start_o) begin
            state <= BUSY;
            cnt   <= CNT_W'(MDU_LAT - 1);
        end else if (state == BUSY) begin
            if (cnt != '0)
                cnt <= cnt - 1'b1;
            else if (!mem_frz_i)
                state <= RUN;
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline enable/flush controller (load-use, branch, memory and MDU freezes)
// Optional HAZARD_PERF_EN adds saturating stall counters and their ports.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 4
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [REG_BITS-1:0] id_rs1_addr_i,
    input  logic [REG_BITS-1:0] id_rs2_addr_i,
    input  logic                id_rs1_use_i,
    input  logic                id_rs2_use_i,
    input  logic                exe_mem_rd_i,
    input  logic [REG_BITS-1:0] exe_rd_addr_i,
    input  logic                exe_br_taken_i,
    input  logic                exe_mdu_op_i,
    input  logic                im_stall_i,
    input  logic                dm_stall_i,
    output logic                pc_en_o,
    output logic                if_id_en_o,
    output logic                id_exe_en_o,
    output logic                exe_mem_en_o,
    output logic                mem_wb_en_o,
    output logic                if_id_flush_o,
    output logic                id_exe_flush_o,
    output logic                mdu_start_o,
    output logic                mdu_busy_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]         perf_mem_o,
    output logic [31:0]         perf_mdu_o,
    output logic [31:0]         perf_lu_o
`endif
);
    logic mem_frz, mdu_frz, frz, lu;

    assign mem_frz = im_stall_i | dm_stall_i;
    assign frz     = mem_frz | mdu_frz;
    assign lu      = exe_mem_rd_i && exe_rd_addr_i != '0 &&
                     ((id_rs1_use_i && id_rs1_addr_i == exe_rd_addr_i) ||
                      (id_rs2_use_i && id_rs2_addr_i == exe_rd_addr_i));

    hazard_ctrl_mdu_seq #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) u_mdu_seq (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .mdu_op_i   (exe_mdu_op_i),
        .mem_frz_i  (mem_frz),
        .mdu_frz_o  (mdu_frz),
        .mdu_start_o(mdu_start_o),
        .mdu_busy_o (mdu_busy_o)
    );

    // freeze beats branch, branch beats load-use (ID instruction is wrong-path)
    always_comb begin
        pc_en_o        = !frz && (exe_br_taken_i || !lu);
        if_id_en_o     = pc_en_o;
        id_exe_en_o    = !frz;
        exe_mem_en_o   = !frz;
        mem_wb_en_o    = !frz;
        if_id_flush_o  = !frz && exe_br_taken_i;
        id_exe_flush_o = !frz && (exe_br_taken_i || lu);
    end

`ifdef HAZARD_PERF_EN
    logic lu_ins;
    assign lu_ins = !frz && !exe_br_taken_i && lu;

    // saturating counters of memory freezes, MDU-only freezes and inserted bubbles
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            perf_mem_o <= '0;
            perf_mdu_o <= '0;
            perf_lu_o  <= '0;
        end else begin
            if (mem_frz && perf_mem_o != '1)
                perf_mem_o <= perf_mem_o + 1'b1;
            if (mdu_frz && !mem_frz && perf_mdu_o != '1)
                perf_mdu_o <= perf_mdu_o + 1'b1;
            if (lu_ins && perf_lu_o != '1)
                perf_lu_o <= perf_lu_o + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed + randomized checks of hazard_ctrl against a timestamp-based model
module tb_hazard_ctrl;
    localparam int LAT = 4;

    logic       clk = 0;
    logic       rstn = 0;
    logic [4:0] rs1 = 0, rs2 = 0, rd = 0;
    logic       use1 = 0, use2 = 0, mem_rd = 0, br = 0, mdu_op = 0, im_st = 0, dm_st = 0;
    logic       pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en, if_id_fl, id_exe_fl, start, busy;
`ifdef HAZARD_PERF_EN
    logic [31:0] p_mem, p_mdu, p_lu;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // model: an MDU op is in flight from its start; it counts cycles since start
    bit in_flight = 0;
    int age = 0;

    hazard_ctrl #(.MDU_LAT(LAT), .CNT_W(4)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
        .id_rs1_use_i(use1), .id_rs2_use_i(use2),
        .exe_mem_rd_i(mem_rd), .exe_rd_addr_i(rd),
        .exe_br_taken_i(br), .exe_mdu_op_i(mdu_op),
        .im_stall_i(im_st), .dm_stall_i(dm_st),
        .pc_en_o(pc_en), .if_id_en_o(if_id_en), .id_exe_en_o(id_exe_en),
        .exe_mem_en_o(exe_mem_en), .mem_wb_en_o(mem_wb_en),
        .if_id_flush_o(if_id_fl), .id_exe_flush_o(id_exe_fl),
        .mdu_start_o(start), .mdu_busy_o(busy)
`ifdef HAZARD_PERF_EN
        , .perf_mem_o(p_mem), .perf_mdu_o(p_mdu), .perf_lu_o(p_lu)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] dut_vec();
        return {pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en, if_id_fl, id_exe_fl, start, busy};
    endfunction

    // expected {pc,if_id,id_exe,exe_mem,mem_wb,if_fl,id_fl,start,busy} from the priority rules
    function automatic logic [8:0] model_vec();
        bit memf, mduf, hz, lu_hit, st;
        memf = im_st || dm_st;
        st   = !in_flight && mdu_op && !memf;
        mduf = in_flight ? (age < LAT || memf) : mdu_op;
        hz   = memf || mduf;
        lu_hit = mem_rd && rd != 0 && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
        if (hz)
            return {7'b0, st, in_flight};
        if (br)
            return {7'b1111111, st, in_flight};
        if (lu_hit)
            return {7'b0011101, st, in_flight};
        return {7'b1111100, st, in_flight};
    endfunction

    // advance the model on each edge; reset clears any in-flight op
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_flight = 0;
            age = 0;
        end else if (in_flight) begin
            if (age >= LAT && !(im_st || dm_st))
                in_flight = 0;
            else
                age++;
        end else if (mdu_op && !(im_st || dm_st)) begin
            in_flight = 1;
            age = 1;
        end
    end

    // every cycle: DUT outputs must match the model
    always @(negedge clk) begin
        logic [8:0] e, a;
        e = model_vec();
        a = dut_vec();
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL model t=%0t got=%b exp=%b", $time, a, e);
        end
    end

    task automatic chk(input string name, input logic [8:0] exp);
        @(negedge clk);
        #1;
        n_checks++;
        if (dut_vec() !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", name, dut_vec(), exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1 = 0; rs2 = 0; rd = 0; use1 = 0; use2 = 0; mem_rd = 0;
        br = 0; mdu_op = 0; im_st = 0; dm_st = 0;
    endtask

    initial begin
        idle();
        #12 rstn = 1;
        @(posedge clk);
        #1;
        chk("reset_idle", 9'b111110000);
        // add x5,x6,x7 behind lw x6
        rs1 = 6; rs2 = 7; use1 = 1; use2 = 1; mem_rd = 1; rd = 6;
        chk("lu_bubble", 9'b001110100);
        mem_rd = 0;
        chk("lu_after", 9'b111110000);
        rs1 = 0; rd = 0; mem_rd = 1;
        chk("x0_no_hazard", 9'b111110000);
        rs1 = 6; rd = 6; br = 1;
        chk("br_over_lu", 9'b111111100);
        idle();
        mdu_op = 1;
        chk("mdu_c0", 9'b000000010);
        chk("mdu_c1", 9'b000000001);
        chk("mdu_c2", 9'b000000001);
        chk("mdu_c3", 9'b000000001);
        chk("mdu_c4", 9'b111110001);
        mdu_op = 0;
        chk("mdu_c5", 9'b111110000);
        mdu_op = 1;
        chk("mdus_c0", 9'b000000010);
        for (int i = 1; i < 4; i++) chk("mdus_busy", 9'b000000001);
        dm_st = 1;
        for (int i = 0; i < 3; i++) chk("mdus_memhold", 9'b000000001);
        dm_st = 0;
        chk("mdus_release", 9'b111110001);
        mdu_op = 0;
        chk("mdus_after", 9'b111110000);
        mdu_op = 1;
        chk("mdur_c0", 9'b000000010);
        chk("mdur_c1", 9'b000000001);
        @(negedge clk);
        #1;
        rstn = 0;
        mdu_op = 0;
        #1;
        n_checks++;
        if (dut_vec() !== 9'b111110000) begin
            n_fail++;
            $display("FAIL reset_mid_busy got=%b exp=%b", dut_vec(), 9'b111110000);
        end
        @(posedge clk);
        #1;
        rstn = 1;
        chk("reset_release_idle", 9'b111110000);
        for (int i = 0; i < 3000; i++) begin
            rs1 = 5'($urandom_range(0, 3));
            rs2 = 5'($urandom_range(0, 3));
            rd = 5'($urandom_range(0, 3));
            use1 = 1'($urandom);
            use2 = 1'($urandom);
            mem_rd = 1'($urandom);
            br = $urandom_range(0, 7) == 0;
            mdu_op = $urandom_range(0, 5) == 0 || (busy && $urandom_range(0, 1) == 0);
            im_st = $urandom_range(0, 7) == 0;
            dm_st = $urandom_range(0, 7) == 0;
            rstn = $urandom_range(0, 199) != 0;
            @(posedge clk);
            #1;
        end
        rstn = 1;
        idle();
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32 core (IF/ID/EXE/MEM/WB).
- Owns every stage-register enable and flush: load-use bubbles, taken-branch/jump flushes, memory-wait freezes, and fixed-latency multi-cycle MUL/DIV freezes.
- Sits beside the EXE-stage forwarding mux select logic and covers the hazards forwarding cannot resolve.
- All outputs combinational from inputs plus internal MDU state; enables consumed by pipeline registers on the same edge.

Parameters:
- MDU_LAT, 4, EXE stall cycles per MUL/DIV op; legal 1..15.
- CNT_W, 4, MDU countdown width; must satisfy 2**CNT_W > MDU_LAT.

Ports:
- clk_i  input  1  core clock.
- rstn_i  input  1  asynchronous active-low reset.
- id_rs1_addr_i  input  5  ID rs1 index.
- id_rs2_addr_i  input  5  ID rs2 index.
- id_rs1_use_i  input  1  ID instruction reads rs1.
- id_rs2_use_i  input  1  ID instruction reads rs2.
- exe_mem_rd_i  input  1  EXE instruction is a load.
- exe_rd_addr_i  input  5  EXE destination index.
- exe_br_taken_i  input  1  EXE branch/jump redirects PC.
- exe_mdu_op_i  input  1  EXE instruction is MUL/DIV.
- im_stall_i  input  1  instruction memory not ready.
- dm_stall_i  input  1  data memory not ready.
- pc_en_o  output  1  PC register update enable.
- if_id_en_o  output  1  IF/ID register enable.
- id_exe_en_o  output  1  ID/EXE register enable.
- exe_mem_en_o  output  1  EXE/MEM register enable.
- mem_wb_en_o  output  1  MEM/WB register enable.
- if_id_flush_o  output  1  load NOP into IF/ID.
- id_exe_flush_o  output  1  load NOP into ID/EXE.
- mdu_start_o  output  1  one-cycle pulse; MDU latches operands.
- mdu_busy_o  output  1  MDU FSM in BUSY.

Behaviour:
- Reset (rstn_i low, async): FSM=RUN, cnt=0, mdu_start_o=0, mdu_busy_o=0.
  - All enables=1, flushes=0 once inputs are idle; enables are pure comb of state, so no held-low freeze while in reset.
- mem_frz = im_stall_i | dm_stall_i.
- mdu_frz = (RUN & exe_mdu_op_i) | (BUSY & !(cnt==0 & !mem_frz)).
- frz = mem_frz | mdu_frz.
- FSM RUN:
  - If exe_mdu_op_i & !mem_frz: mdu_start_o=1, cnt<=MDU_LAT-1, go BUSY.
  - If exe_mdu_op_i & mem_frz: stay RUN, no start.
- FSM BUSY:
  - mdu_busy_o=1.
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0 & !mem_frz: release (mdu_frz=0 this cycle, the MUL/DIV advances to MEM), go RUN.
  - If cnt==0 & mem_frz: hold.
- Net MDU cost: exactly MDU_LAT freeze cycles when there is no memory stall.
- Back-to-back MDU ops: the next op arrives in EXE a later cycle and restarts from RUN.
- Priority, highest first:
  1. frz: all five enables=0, both flushes=0. Branch and load-use outcomes are deferred; EXE/ID contents are held, so they re-evaluate after release.
  2. exe_br_taken_i: all enables=1, if_id_flush_o=1, id_exe_flush_o=1. This overrides load-use, because the ID instruction is wrong-path.
  3. load-use = exe_mem_rd_i & (exe_rd_addr_i!=0) & ((id_rs1_use_i & id_rs1_addr_i==exe_rd_addr_i) | (id_rs2_use_i & id_rs2_addr_i==exe_rd_addr_i)).
     - Response: pc_en_o=0, if_id_en_o=0, id_exe_flush_o=1, id_exe_en_o=1, exe_mem_en_o=1, mem_wb_en_o=1.
     - Exactly one bubble; the next cycle sees the load in MEM, and forwarding covers it.
  4. else: all enables=1, flushes=0.
- A flush is only ever asserted with the matching enable=1.
- x0 is never a hazard source.

Optional Feature:
- HAZARD_PERF_EN defined adds three 32-bit saturating counters and ports perf_mem_o, perf_mdu_o, perf_lu_o (output 32 each).
  - Counters: mem_frz cycles, mdu_frz-only cycles (mdu_frz & !mem_frz), load-use bubbles actually inserted.
  - All counters async-reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared CPU_def package holds:
  - the REG_BITS width macro;
  - the hazard_state_e enum {RUN, BUSY};
  - a NOP-encoding constant used by flushes.
- One natural sub-module: mdu_seq (FSM + countdown, producing mdu_frz/mdu_start_o/mdu_busy_o).
- Hazard priority logic stays at the top level.

Test Plan:
- ID add x5,x6,x7 with EXE lw x6 -> cycle 0: pc_en=0, if_id_en=0, id_exe_flush=1; next cycle all enables=1, no flush.
- Same pattern but exe_rd_addr=0 with ID rs1=0 -> no bubble, all enables=1.
- exe_br_taken_i=1 together with a load-use match -> if_id_flush=1, id_exe_flush=1, pc_en=1, no bubble.
- exe_mdu_op_i=1, MDU_LAT=4, no memory stalls -> mdu_start_o pulses at cycle 0; enables=0 for cycles 0-3; all enables=1 at cycle 4; mdu_busy_o high cycles 1-4.
- MDU in BUSY, cnt reaches 0 while dm_stall_i=1 for 3 cycles -> freeze is held 3 extra cycles, then released on the first cycle dm_stall_i=0; cnt does not underflow.
- Assert rstn_i low mid-BUSY (cnt=2) -> immediate RUN, mdu_busy_o=0; after release, an idle bench sees all enables=1.
